// File: rtl/eth_frame_loop_mem_pkg.sv
// Shared types and constants for the frame-loop script-memory AXI4-Lite master.
package eth_frame_loop_mem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CAP  = 3'd1,
    RD_CAP  = 3'd2,
    MEM     = 3'd3,
    WR_RESP = 3'd4,
    RD_RESP = 3'd5
  } mem_master_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte-address width covering all script sections (4 copies per script).
  function automatic int unsigned mem_addr_width(input int unsigned num_scripts,
                                                 input int unsigned max_size);
    return $clog2(4 * num_scripts * max_size);
  endfunction

endpackage

// File: rtl/eth_frame_loop_mem_master.sv
// AXI4-Lite slave that turns single reads/writes into script-RAM req/ack transactions.
// Optional ack timeout: define ETH_FRAME_LOOP_MEM_TIMEOUT_EN.
module eth_frame_loop_mem_master
  import eth_frame_loop_mem_pkg::*;
#(
  parameter int unsigned C_AXI_WIDTH       = 32,
  parameter int unsigned C_AXI_ADDR_WIDTH  = 32,
  parameter int unsigned C_NUM_SCRIPTS     = 4,
  parameter int unsigned C_MAX_SCRIPT_SIZE = 2048,
  parameter int unsigned C_TIMEOUT_CYCLES  = 256,
  localparam int unsigned MEM_AW = mem_addr_width(C_NUM_SCRIPTS, C_MAX_SCRIPT_SIZE),
  localparam int unsigned STRB_W = C_AXI_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [C_AXI_WIDTH-1:0]      s_axi_wdata,
  input  logic [STRB_W-1:0]           s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [C_AXI_WIDTH-1:0]      s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic                        mem_req,
  output logic [MEM_AW-1:0]           mem_addr,
  output logic                        mem_wenable,
  output logic [C_AXI_WIDTH-1:0]      mem_wdata,
  input  logic [C_AXI_WIDTH-1:0]      mem_rdata,
  input  logic                        mem_ack
);

  mem_master_state_t state_q, state_d;

  logic                        prefer_read_q, prefer_read_d;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [C_AXI_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_W-1:0]           strb_q, strb_d;

  logic                        awready_d, wready_d, arready_d;
  logic                        bvalid_d, rvalid_d;
  logic [1:0]                  bresp_d, rresp_d;
  logic [C_AXI_WIDTH-1:0]      rdata_d;
  logic                        mem_req_d, mem_wenable_d;
  logic [MEM_AW-1:0]           mem_addr_d;
  logic [C_AXI_WIDTH-1:0]      mem_wdata_d;

  logic addr_err, strb_err, is_wr_cap;

  assign addr_err  = (addr_q >> MEM_AW) != '0;
  assign strb_err  = strb_q != '1;
  assign is_wr_cap = state_q == WR_CAP;

`ifdef ETH_FRAME_LOOP_MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(C_TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + TMO_W'(1);
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      prefer_read_q <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= 2'b00;
      s_axi_rdata   <= '0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
      mem_wenable   <= 1'b0;
      mem_wdata     <= '0;
`ifdef ETH_FRAME_LOOP_MEM_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      prefer_read_q <= prefer_read_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_arready <= arready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rresp   <= rresp_d;
      s_axi_rdata   <= rdata_d;
      mem_req       <= mem_req_d;
      mem_addr      <= mem_addr_d;
      mem_wenable   <= mem_wenable_d;
      mem_wdata     <= mem_wdata_d;
`ifdef ETH_FRAME_LOOP_MEM_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    prefer_read_d = prefer_read_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    awready_d     = 1'b0;
    wready_d      = 1'b0;
    arready_d     = 1'b0;
    bvalid_d      = s_axi_bvalid;
    bresp_d       = s_axi_bresp;
    rvalid_d      = s_axi_rvalid;
    rresp_d       = s_axi_rresp;
    rdata_d       = s_axi_rdata;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    mem_wenable_d = mem_wenable;
    mem_wdata_d   = mem_wdata;
`ifdef ETH_FRAME_LOOP_MEM_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        // Round-robin: a write wins only if no read is pending or a read went last.
        if (s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !prefer_read_q)) begin
          awready_d     = 1'b1;
          wready_d      = 1'b1;
          addr_d        = s_axi_awaddr;
          wdata_d       = s_axi_wdata;
          strb_d        = s_axi_wstrb;
          prefer_read_d = 1'b1;
          state_d       = WR_CAP;
        end else if (s_axi_arvalid) begin
          arready_d     = 1'b1;
          addr_d        = s_axi_araddr;
          prefer_read_d = 1'b0;
          state_d       = RD_CAP;
        end
      end

      WR_CAP, RD_CAP: begin
        if (addr_err || (is_wr_cap && strb_err)) begin
          if (is_wr_cap) begin
            bvalid_d = 1'b1;
            bresp_d  = addr_err ? RESP_DECERR : RESP_SLVERR;
            state_d  = WR_RESP;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
            rdata_d  = '0;
            state_d  = RD_RESP;
          end
        end else begin
          mem_req_d     = 1'b1;
          mem_addr_d    = MEM_AW'(addr_q);
          mem_wenable_d = is_wr_cap;
          if (is_wr_cap) mem_wdata_d = wdata_q;
`ifdef ETH_FRAME_LOOP_MEM_TIMEOUT_EN
          cnt_d         = '0;
`endif
          state_d       = MEM;
        end
      end

      MEM: begin
        if (mem_ack) begin
          mem_req_d     = 1'b0;
          mem_wenable_d = 1'b0;
          if (mem_wenable) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            state_d  = WR_RESP;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = mem_rdata;
            state_d  = RD_RESP;
          end
        end
`ifdef ETH_FRAME_LOOP_MEM_TIMEOUT_EN
        // Ack has priority over a timeout landing on the same cycle.
        else if (cnt_inc == TMO_W'(C_TIMEOUT_CYCLES)) begin
          mem_req_d     = 1'b0;
          mem_wenable_d = 1'b0;
          if (mem_wenable) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_SLVERR;
            state_d  = WR_RESP;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
            rdata_d  = '0;
            state_d  = RD_RESP;
          end
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end

      WR_RESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      RD_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_frame_loop_mem_master.sv
// Directed and randomized checks of eth_frame_loop_mem_master against a transaction-level model.
module tb_eth_frame_loop_mem_master;
  import eth_frame_loop_mem_pkg::*;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata, mem_wdata, mem_rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic        mem_req, mem_wenable, mem_ack;
  logic [14:0] mem_addr;

  eth_frame_loop_mem_master #(.C_TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wenable(mem_wenable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Fake script RAM driven by the DUT, and the bench's own expectation of its contents.
  logic [31:0] ram     [logic [14:0]];
  logic [31:0] ref_mem [logic [14:0]];

  // Per-transaction observations.
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata, m_wdata;
  logic [14:0] m_addr;
  logic        m_wen;
  int          n_mem, req_len, first_srv, rv_lat;
  bit          hold_bad, rstab_bad, all_done;
  logic        wen_log [$];

  function automatic logic [31:0] init_val(input logic [14:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [14:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [14:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs an optional write and/or read, acting as AXI master and as the memory (ack_dly 0 = never ack).
  task automatic txn(input bit do_wr, input bit do_rd, input logic [31:0] waddr,
                     input logic [31:0] wdat, input logic [3:0] strb, input logic [31:0] raddr,
                     input int ack_dly, input int rdy_dly);
    bit aw_pend = 0, ar_pend = 0, b_fin = 0, r_fin = 0, prev_req = 0, rv_seen = 0;
    bit b_done = !do_wr, r_done = !do_rd;
    int cyc = 0, mem_run = 0, bwait = 0, rwait = 0;
    logic [31:0] rd_cap;
    logic [1:0]  rr_cap;
    n_mem = 0; req_len = 0; first_srv = 0; rv_lat = -1; hold_bad = 0; rstab_bad = 0;
    r_bresp = 2'bxx; r_rresp = 2'bxx; r_rdata = 'x; m_addr = 'x; m_wen = 1'bx; m_wdata = 'x;
    wen_log.delete();
    @(negedge clk);
    awaddr = waddr; wdata = wdat; wstrb = strb; araddr = raddr;
    awvalid = do_wr; wvalid = do_wr; arvalid = do_rd;
    while (!(b_done && r_done) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (aw_pend) begin awvalid = 1'b0; wvalid = 1'b0; aw_pend = 0; end
      if (ar_pend) begin arvalid = 1'b0; ar_pend = 0; end
      if (awvalid && awready && wready) begin aw_pend = 1; if (first_srv == 0) first_srv = 2; end
      if (arvalid && arready) begin ar_pend = 1; if (first_srv == 0) first_srv = 1; end
      if (mem_req) begin
        if (!prev_req) begin
          n_mem++; mem_run = 0;
          m_addr = mem_addr; m_wen = mem_wenable; m_wdata = mem_wdata;
          wen_log.push_back(mem_wenable);
        end else if (mem_addr !== m_addr || mem_wenable !== m_wen || mem_wdata !== m_wdata) begin
          hold_bad = 1;
        end
        mem_run++;
        req_len = mem_run;
        if (mem_run == ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = mem_wenable ? $urandom : ram_rd(mem_addr);
          if (mem_wenable) ram[mem_addr] = mem_wdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end
      prev_req = mem_req;
      if (!b_done) begin
        if (b_fin) begin bready = 1'b0; b_done = 1; end
        else if (bvalid) begin
          if (bwait >= rdy_dly) begin bready = 1'b1; b_fin = 1; r_bresp = bresp; end
          bwait++;
        end
      end
      if (!r_done) begin
        if (r_fin) begin rready = 1'b0; r_done = 1; end
        else if (rvalid) begin
          if (!rv_seen) begin rv_seen = 1; rd_cap = rdata; rr_cap = rresp; rv_lat = cyc; end
          else if (rdata !== rd_cap || rresp !== rr_cap) rstab_bad = 1;
          if (rwait >= rdy_dly) begin rready = 1'b1; r_fin = 1; r_rdata = rdata; r_rresp = rresp; end
          rwait++;
        end
      end
    end
    all_done = b_done && r_done;
    check("txn_completed_in_bound", 64'(all_done), 64'd1);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0; mem_ack = 1'b0;
  endtask

  logic [31:0] ra, wd, exp_rd;
  logic [3:0]  st;
  logic [1:0]  exp_resp, order;
  bit          is_wr, ar_p, got_req;

  initial begin
    do_reset();
    rst_n = 1'b0;
    #3;
    check("reset_handshakes", 64'({awready, wready, arready, bvalid, rvalid, mem_req, mem_wenable}), 64'd0);
    check("reset_resp_data", 64'({bresp, rresp, rdata}), 64'd0);
    check("reset_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", 64'({awready, arready, bvalid, rvalid, mem_req}), 64'd0);

    // Directed write with a 2-cycle ack.
    txn(1, 0, 32'h0000_0104, 32'hDEAD_BEEF, 4'hF, 32'h0, 2, 0);
    ref_mem[15'h104] = 32'hDEAD_BEEF;
    check("wr_mem_count", 64'(n_mem), 64'd1);
    check("wr_req_len", 64'(req_len), 64'd2);
    check("wr_mem_addr", 64'(m_addr), 64'h104);
    check("wr_mem_wen", 64'(m_wen), 64'd1);
    check("wr_mem_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
    check("wr_mem_hold", 64'(hold_bad), 64'd0);
    check("wr_bresp", 64'(r_bresp), 64'(RESP_OKAY));

    // Directed read with a 1-cycle ack and rready held off 5 cycles.
    ram[15'h104] = 32'h1234_5678;
    ref_mem[15'h104] = 32'h1234_5678;
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0104, 1, 5);
    check("rd_latency", 64'(rv_lat), 64'd3);
    check("rd_rdata", 64'(r_rdata), 64'h1234_5678);
    check("rd_rresp", 64'(r_rresp), 64'(RESP_OKAY));
    check("rd_stable", 64'(rstab_bad), 64'd0);
    check("rd_mem_wen", 64'(m_wen), 64'd0);
    check("rd_mem_addr", 64'(m_addr), 64'h104);

    // Out-of-range read and partial-strobe write.
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_8000, 1, 1);
    check("decerr_no_mem", 64'(n_mem), 64'd0);
    check("decerr_rresp", 64'(r_rresp), 64'(RESP_DECERR));
    check("decerr_rdata", 64'(r_rdata), 64'd0);
    txn(1, 0, 32'h0000_0040, 32'hAAAA_5555, 4'h3, 32'h0, 1, 1);
    check("slverr_no_mem", 64'(n_mem), 64'd0);
    check("slverr_bresp", 64'(r_bresp), 64'(RESP_SLVERR));

    // Simultaneous read and write from reset, twice.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      wd = $urandom;
      txn(1, 1, 32'h0000_0200, wd, 4'hF, 32'h0000_0300, 1, 0);
      ref_mem[15'h200] = wd;
      order = (wen_log.size() == 2) ? {wen_log[0], wen_log[1]} : 2'bxx;
      check("arb_first_read", 64'(first_srv), 64'd1);
      check("arb_mem_gap_count", 64'(n_mem), 64'd2);
      check("arb_mem_order", 64'(order), 64'b01);
      check("arb_rdata", 64'(r_rdata), 64'(ref_rd(15'h300)));
      check("arb_bresp", 64'(r_bresp), 64'(RESP_OKAY));
    end

    // Asynchronous reset while waiting for ack.
    @(negedge clk);
    araddr = 32'h0000_0010; arvalid = 1'b1; ar_p = 0; got_req = 0;
    for (int i = 0; i < 10 && !got_req; i++) begin
      @(negedge clk);
      if (ar_p) begin arvalid = 1'b0; ar_p = 0; end
      if (arvalid && arready) ar_p = 1;
      if (mem_req) got_req = 1;
    end
    check("rst_mid_reached_mem", 64'(got_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_mid_mem_req_async", 64'({mem_req, rvalid}), 64'd0);
    arvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0104, 1, 0);
    check("rst_mid_fresh_rresp", 64'(r_rresp), 64'(RESP_OKAY));
    check("rst_mid_fresh_rdata", 64'(r_rdata), 64'(ref_rd(15'h104)));

    // Randomized traffic against the transaction model.
    for (int n = 0; n < 40; n++) begin
      is_wr = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 4) != 0) ra = 32'($urandom_range(0, 255));
      else ra = {17'($urandom_range(1, 131071)), 15'($urandom_range(0, 255))};
      st = ($urandom_range(0, 6) != 0) ? 4'hF : 4'($urandom_range(0, 14));
      wd = $urandom;
      exp_resp = (ra[31:15] != 0) ? RESP_DECERR : (is_wr && st != 4'hF) ? RESP_SLVERR : RESP_OKAY;
      exp_rd = (exp_resp == RESP_OKAY) ? ref_rd(ra[14:0]) : 32'h0;
      txn(is_wr, !is_wr, ra, wd, st, ra, $urandom_range(1, 4), $urandom_range(0, 3));
      check("rnd_mem_count", 64'(n_mem), 64'(exp_resp == RESP_OKAY));
      check("rnd_mem_hold", 64'(hold_bad), 64'd0);
      if (exp_resp == RESP_OKAY) begin
        check("rnd_mem_addr", 64'(m_addr), 64'(ra[14:0]));
        check("rnd_mem_wen", 64'(m_wen), 64'(is_wr));
      end
      if (is_wr) begin
        check("rnd_bresp", 64'(r_bresp), 64'(exp_resp));
        if (exp_resp == RESP_OKAY) begin
          check("rnd_mem_wdata", 64'(m_wdata), 64'(wd));
          ref_mem[ra[14:0]] = wd;
        end
      end else begin
        check("rnd_rresp", 64'(r_rresp), 64'(exp_resp));
        check("rnd_rdata", 64'(r_rdata), 64'(exp_rd));
        check("rnd_rdata_stable", 64'(rstab_bad), 64'd0);
      end
    end

`ifdef ETH_FRAME_LOOP_MEM_TIMEOUT_EN
    // No ack: request is abandoned after TMO cycles with SLVERR.
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0104, 0, 0);
    check("tmo_req_len", 64'(req_len), 64'(TMO));
    check("tmo_rresp", 64'(r_rresp), 64'(RESP_SLVERR));
    check("tmo_rdata", 64'(r_rdata), 64'd0);
    // Ack on the final cycle still completes normally.
    txn(0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0104, TMO, 0);
    check("tmo_edge_req_len", 64'(req_len), 64'(TMO));
    check("tmo_edge_rresp", 64'(r_rresp), 64'(RESP_OKAY));
    check("tmo_edge_rdata", 64'(r_rdata), 64'(ref_rd(15'h104)));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
